// File: rtl/prog_rom_seq_pkg.sv
// prog_rom_seq_pkg
// Shared definitions for the programmable ROM sequencer:
//   OPC_W                          opcode field width
//   OP_INC/OP_JNO/OP_HLT/OP_NOP    opcode encodings
//   state_t                        sequencer FSM states
package prog_rom_seq_pkg;

  localparam int OPC_W = 2;

  localparam logic [OPC_W-1:0] OP_INC = 2'b00;
  localparam logic [OPC_W-1:0] OP_JNO = 2'b01;
  localparam logic [OPC_W-1:0] OP_HLT = 2'b10;
  localparam logic [OPC_W-1:0] OP_NOP = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/prog_rom_mem.sv
// prog_rom_mem
// Program storage: 2**ADDR_W words of {opcode, target}, synchronous write,
// registered read. Contents are never reset.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write strobe
//   waddr  in   write address
//   wdata  in   write data {opcode, target}
//   re     in   read enable; rdata updates only when set
//   raddr  in   read address
//   rdata  out  registered read data
module prog_rom_mem
  import prog_rom_seq_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [OPC_W+ADDR_W-1:0] wdata,
  input  logic                    re,
  input  logic [ADDR_W-1:0]       raddr,
  output logic [OPC_W+ADDR_W-1:0] rdata
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int WORD_W = OPC_W + ADDR_W;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/prog_rom_seq.sv
// prog_rom_seq
// Self-running fetch/execute sequencer over a writable program memory.
// Each instruction takes two cycles (FETCH reads mem[pc] into the
// instruction register, EXEC performs it).
// Optional feature macro: ROM_SEQ_WDOG_EN (instruction-count watchdog).
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   run request, accepted in IDLE or HALT
//   prog_we    in   program write strobe, honoured in IDLE or HALT
//   prog_addr  in   program write address
//   prog_data  in   program word {opcode, target}
//   busy       out  high in FETCH/EXEC
//   done       out  high in HALT
//   pc         out  program counter
//   acc        out  accumulator
//   ovf        out  carry out of the most recent INC
//   wdog_to    out  watchdog timeout flag
module prog_rom_seq
  import prog_rom_seq_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int ADDR_W     = 2,
  parameter int WDOG_STEPS = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    prog_we,
  input  logic [ADDR_W-1:0]       prog_addr,
  input  logic [OPC_W+ADDR_W-1:0] prog_data,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       pc,
  output logic [DATA_W-1:0]       acc,
  output logic                    ovf,
  output logic                    wdog_to
);

  localparam int WORD_W = OPC_W + ADDR_W;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                ovf_q, ovf_d;

  logic [WORD_W-1:0]   ir;
  logic [OPC_W-1:0]    opcode;
  logic [ADDR_W-1:0]   target;
  logic [DATA_W:0]     inc_sum;
  logic [ADDR_W-1:0]   pc_inc;
  logic                ctrl_free;
  logic                start_ok;
  logic                mem_we;
  logic                wdog_fire;

  // Loading and starting are only legal while the engine is parked.
  assign ctrl_free = (state_q == IDLE) || (state_q == HALT);
  assign start_ok  = start && ctrl_free;
  assign mem_we    = prog_we && ctrl_free;

  prog_rom_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (state_q == FETCH),
    .raddr (pc_q),
    .rdata (ir)
  );

  assign opcode  = ir[WORD_W-1 -: OPC_W];
  assign target  = ir[ADDR_W-1:0];
  assign inc_sum = {1'b0, acc_q} + {{DATA_W{1'b0}}, 1'b1};
  assign pc_inc  = pc_q + ADDR_W'(1);

`ifdef ROM_SEQ_WDOG_EN
  localparam int STEP_W = $clog2(WDOG_STEPS + 1);

  logic [STEP_W-1:0] step_q, step_d;
  logic              wdog_q, wdog_d;

  // The EXEC that completes the WDOG_STEPS-th instruction still executes,
  // then parks in HALT instead of fetching again. A real HLT wins.
  assign wdog_fire = (state_q == EXEC) && (opcode != OP_HLT) &&
                     (step_q == STEP_W'(WDOG_STEPS - 1));

  always_comb begin
    step_d = step_q;
    wdog_d = wdog_q;
    if (start_ok) begin
      step_d = '0;
      wdog_d = 1'b0;
    end else if (state_q == EXEC) begin
      if (step_q != STEP_W'(WDOG_STEPS)) begin
        step_d = step_q + STEP_W'(1);
      end
      if (wdog_fire) begin
        wdog_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      wdog_q <= 1'b0;
    end else begin
      step_q <= step_d;
      wdog_q <= wdog_d;
    end
  end

  assign wdog_to = wdog_q;
`else
  assign wdog_fire = 1'b0;
  // WDOG_STEPS is kept on the interface so both builds share one port map.
  assign wdog_to   = 1'b0 & (WDOG_STEPS > 0);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, HALT: begin
        if (start_ok) begin
          state_d = FETCH;
          pc_d    = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      FETCH: begin
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        case (opcode)
          OP_INC: begin
            {ovf_d, acc_d} = inc_sum;
            pc_d           = pc_inc;
          end
          OP_JNO: begin
            pc_d = ovf_q ? pc_inc : target;
          end
          OP_HLT: begin
            state_d = HALT;
          end
          default: begin
            pc_d = pc_inc;
          end
        endcase
        if (wdog_fire) begin
          state_d = HALT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == FETCH) || (state_q == EXEC);
  assign done = (state_q == HALT);
  assign pc   = pc_q;
  assign acc  = acc_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_prog_rom_seq.sv
module tb_prog_rom_seq;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 2;
`ifdef ROM_SEQ_WDOG_EN
  localparam int WDOG_STEPS = 10;
`else
  localparam int WDOG_STEPS = 64;
`endif
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int AMAX  = (1 << DATA_W);

  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] J = 2'b01;
  localparam logic [1:0] H = 2'b10;
  localparam logic [1:0] N = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              prog_we = 1'b0;
  logic [ADDR_W-1:0] prog_addr = '0;
  logic [ADDR_W+1:0] prog_data = '0;
  logic              busy, done, ovf, wdog_to;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] acc;

  int checks = 0;
  int errors = 0;

  prog_rom_seq #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WDOG_STEPS(WDOG_STEPS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .busy(busy),
    .done(done), .pc(pc), .acc(acc), .ovf(ovf), .wdog_to(wdog_to)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4*(ADDR_W+2)-1:0] words;  // word a at [a*4 +: 4]
    int cyc;
    int acc;
    int ovf;
    int pc;
  } vec_t;

  function automatic logic [ADDR_W+1:0] w(logic [1:0] op, int tg);
    return {op, ADDR_W'(tg)};
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic load(int a, logic [ADDR_W+1:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = ADDR_W'(a); prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic load_prog(logic [4*(ADDR_W+2)-1:0] ws);
    for (int a = 0; a < DEPTH; a++) load(a, ws[a*4 +: 4]);
  endtask

  // Returns at the negedge right after the accepting edge (first FETCH).
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done: timeout after %0d cycles, done=%0d required 1", n, done);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Instruction-level reference: executes a random program and compares the
  // architectural state at every FETCH.
  task automatic run_random(int budget);
    logic [1:0] mop [DEPTH];
    int         mtg [DEPTH];
    int m_pc, m_acc, m_ovf, steps, halted, wd, n;
    for (int a = 0; a < DEPTH; a++) begin
      mop[a] = 2'($urandom_range(0, 3));
      mtg[a] = int'($urandom_range(0, DEPTH - 1));
      load(a, w(mop[a], mtg[a]));
    end
    pulse_start();
    m_pc = 0; m_acc = 0; m_ovf = 0; steps = 0; halted = 0; wd = 0;
    for (int i = 0; i < budget && halted == 0; i++) begin
      chk("rnd_busy", busy, 1);
      chk("rnd_pc", pc, m_pc);
      chk("rnd_acc", acc, m_acc);
      chk("rnd_ovf", ovf, m_ovf);
      case (mop[m_pc])
        I: begin
          m_ovf = (m_acc == AMAX - 1) ? 1 : 0;
          m_acc = (m_acc + 1) % AMAX;
          m_pc  = (m_pc + 1) % DEPTH;
        end
        J: m_pc = m_ovf ? (m_pc + 1) % DEPTH : mtg[m_pc];
        H: halted = 1;
        default: m_pc = (m_pc + 1) % DEPTH;
      endcase
      steps++;
`ifdef ROM_SEQ_WDOG_EN
      if (halted == 0 && steps == WDOG_STEPS) begin
        halted = 1; wd = 1;
      end
`endif
      @(negedge clk);
      @(negedge clk);
    end
    if (halted != 0) begin
      wait_done(2, n);
      chk("rnd_done_cyc", n, 0);
      chk("rnd_h_pc", pc, m_pc);
      chk("rnd_h_acc", acc, m_acc);
      chk("rnd_h_ovf", ovf, m_ovf);
      chk("rnd_wdog", wdog_to, wd);
    end else begin
      chk("rnd_run_done", done, 0);
      do_reset();
    end
  endtask

  initial begin
    vec_t vecs [6];
    int n;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pc", pc, 0);
    chk("rst_acc", acc, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_wdog", wdog_to, 0);
    rst_n = 1'b1;

`ifndef ROM_SEQ_WDOG_EN
    vecs[0] = '{{w(N,0), w(H,0), w(J,0), w(I,0)}, 66, 0, 1, 2};
    vecs[1] = '{{w(N,0), w(H,0), w(I,0), w(I,0)},  6, 2, 0, 2};
    vecs[2] = '{{w(N,0), w(N,0), w(N,0), w(H,0)},  2, 0, 0, 0};
    vecs[3] = '{{w(H,0), w(J,3), w(I,0), w(N,0)},  8, 1, 0, 3};
    vecs[4] = '{{w(H,0), w(J,0), w(N,0), w(I,0)}, 98, 0, 1, 3};
    vecs[5] = '{{w(J,1), w(I,0), w(H,0), w(J,2)},  8, 1, 0, 1};
    for (int v = 0; v < 6; v++) begin
      load_prog(vecs[v].words);
      pulse_start();
      chk("tbl_busy_run", busy, 1);
      wait_done(200, n);
      chk("tbl_cycles", n, vecs[v].cyc);
      chk("tbl_acc", acc, vecs[v].acc);
      chk("tbl_ovf", ovf, vecs[v].ovf);
      chk("tbl_pc", pc, vecs[v].pc);
      chk("tbl_busy_halt", busy, 0);
    end

    // Rerun from HALT restarts from a clean accumulator.
    load_prog(vecs[1].words);
    pulse_start(); wait_done(50, n);
    pulse_start();
    chk("restart_acc0", acc, 0);
    chk("restart_done0", done, 0);
    wait_done(50, n);
    chk("restart_cyc", n, 6);
    chk("restart_acc", acc, 2);

    // Writes and start while busy are ignored.
    pulse_start();
    prog_we = 1'b1; prog_addr = 2'd2; prog_data = w(I, 0); start = 1'b1;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    wait_done(50, n);
    chk("busy_we_cyc", n, 5);
    chk("busy_we_acc", acc, 2);
    // The same write in HALT takes effect on the next run.
    load(2, w(I, 0));
    load(3, w(H, 0));
    pulse_start(); wait_done(50, n);
    chk("halt_we_cyc", n, 8);
    chk("halt_we_acc", acc, 3);
    chk("halt_we_pc", pc, 3);
    // Write and start together: run fetches the freshly written word.
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 2'd0; prog_data = w(H, 0); start = 1'b1;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    wait_done(50, n);
    chk("we_start_cyc", n, 2);
    chk("we_start_pc", pc, 0);

    // Reset during EXEC aborts at once; memory survives.
    load_prog(vecs[0].words);
    pulse_start();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_acc", acc, 0);
    chk("midrst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(); wait_done(200, n);
    chk("midrst_rerun_cyc", n, 66);
    chk("midrst_rerun_ovf", ovf, 1);

    // Running off the end wraps pc; no halt without HLT.
    load_prog({w(I,0), w(N,0), w(N,0), w(N,0)});
    pulse_start();
    for (int c = 0; c <= 40; c++) begin
      if (c % 8 == 0) begin
        chk("wrap_pc", pc, (c / 2) % DEPTH);
        chk("wrap_acc", acc, c / 8);
      end
      if (c < 40) @(negedge clk);
    end
    chk("wrap_done", done, 0);
    do_reset();
`else
    load_prog({w(H,0), w(H,0), w(H,0), w(J,0)});
    pulse_start(); wait_done(100, n);
    chk("wdog_cyc", n, 20);
    chk("wdog_to", wdog_to, 1);
    chk("wdog_done", done, 1);
    pulse_start();
    chk("wdog_clear", wdog_to, 0);
    chk("wdog_busy", busy, 1);
    do_reset();
`endif

    for (int r = 0; r < 20; r++) run_random(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_rom_seq.md
Name: prog_rom_seq

Overview:
Parametrised successor to the fixed 4-entry, 2-bit instruction ROM.
- Writable program memory of 2**ADDR_W words.
- Each word is a 2-bit opcode plus an ADDR_W jump target.
- Includes a fetch/execute sequencer with a program counter, a DATA_W accumulator and an overflow flag.
- Sits between the testbench/loader and the datapath. It is the first self-running instruction engine in the comparch series.

Parameters:
DATA_W, 4, accumulator width in bits (>=2)
ADDR_W, 2, program address width; depth = 2**ADDR_W
WDOG_STEPS, 64, instruction limit before watchdog halt (only with ROM_SEQ_WDOG_EN)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE or HALT
prog_we  in  1  program write strobe; honoured only in IDLE or HALT
prog_addr  in  ADDR_W  program write address
prog_data  in  2+ADDR_W  {opcode[1:0], target[ADDR_W-1:0]}
busy  out  1  high in FETCH/EXEC
done  out  1  high in HALT
pc  out  ADDR_W  current program counter
acc  out  DATA_W  accumulator
ovf  out  1  carry out of most recent INC
wdog_to  out  1  watchdog timeout flag (constant 0 when feature off)

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc=0, acc=0, ovf=0, busy=0, done=0, wdog_to=0. Program memory is NOT reset; contents are retained across rst_n.
- Opcodes:
  - INC=00: {ovf,acc} <= acc+1 (DATA_W+1-bit sum); pc <= pc+1.
  - JNO=01: pc <= target if ovf==0, else pc+1; acc/ovf unchanged.
  - HLT=10: enter HALT; pc, acc and ovf hold.
  - 11=NOP: pc <= pc+1.
- FSM states: IDLE, FETCH, EXEC, HALT.
  - IDLE --start--> FETCH; pc, acc and ovf are cleared on the accepting edge.
  - FETCH: ir <= mem[pc] (registered read); always -> EXEC.
  - EXEC: perform opcode; HLT -> HALT, otherwise -> FETCH.
  - HALT --start--> FETCH with pc, acc and ovf cleared (restart). Without start, HALT holds indefinitely.
- Timing: every instruction takes exactly 2 cycles; done rises the cycle after the EXEC of HLT.
- pc+1 wraps from 2**ADDR_W-1 to 0. Running off the end without HLT loops forever (watchdog aside).
- acc wraps all-ones -> 0 with ovf=1. The next non-wrapping INC clears ovf.
- start while busy is ignored. prog_we while busy is ignored, with no memory change.
- start and prog_we in the same IDLE/HALT cycle: the write completes, and the run starts with FETCH of the updated word on the next cycle.
- rst_n asserted mid-run: the run aborts immediately to IDLE and outputs take their reset values.

Optional Feature:
ROM_SEQ_WDOG_EN.
- Defined: a step counter of clog2(WDOG_STEPS+1) bits counts EXEC cycles and clears on start. When it reaches WDOG_STEPS with no HLT, the FSM enters HALT, wdog_to=1 and done=1. wdog_to clears on the next start or reset.
- Undefined: no counter; wdog_to tied 0; non-halting programs run forever.

Decomposition:
- Shared package prog_rom_seq_pkg holds:
  - opcode constants OP_INC, OP_JNO, OP_HLT, OP_NOP;
  - state enum IDLE/FETCH/EXEC/HALT;
  - OPC_W=2.
- One natural sub-module: prog_rom_mem. It provides the sync-write, registered-read storage (2**ADDR_W x (2+ADDR_W)).

Test Plan:
- Reset mid-run: pulse rst_n low during EXEC -> busy=0, pc=0, acc=0, ovf=0 immediately; memory contents unchanged on readback run.
- Default params, program {0:INC, 1:JNO 0, 2:HLT}, start -> 33 instructions. done rises 66 cycles after start is accepted; acc=0, ovf=1, pc=2.
- Program {0:INC, 1:INC, 2:HLT}, start -> done after 6 cycles, acc=2, ovf=0. A second start -> acc restarts from 0, same result.
- Wrap: program {0:NOP, 1:NOP, 2:NOP, 3:INC} with no HLT, WDOG off -> pc sequence 0,1,2,3,0,...; acc increments every 8 cycles; done stays 0.
- prog_we/start while busy ignored: rewrite addr 2 to INC during the run of the HLT program -> halts as original. The same write in HALT -> the next run takes effect.
- ROM_SEQ_WDOG_EN, WDOG_STEPS=10, program {0:JNO 0} -> HALT after 10 EXECs (20 cycles); wdog_to=1, done=1; start clears wdog_to.
